// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared types and constants for the writeback path of the pipeline.
//   reg_addr_t : 5-bit architectural register index
//   word_t     : default-width data word
//   REG_ZERO   : hard-wired zero register, never written and never pending
//   wb_req_t   : {valid, addr, data} bundle for a writeback requester
// ---------------------------------------------------------------------------
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int WORD_W     = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [WORD_W-1:0]     word_t;

  localparam reg_addr_t REG_ZERO = '0;

  typedef struct packed {
    logic      valid;
    reg_addr_t addr;
    word_t     data;
  } wb_req_t;

endpackage

// File: rtl/wb_scoreboard.sv
// ---------------------------------------------------------------------------
// wb_scoreboard
// Tracks destinations of long-latency ops that have issued but not yet
// written back, and answers the decode-stage hazard questions.
// Ports:
//   clk, reset               : clock, async active-high reset
//   issue_valid/issue_addr   : long-latency issue, marks addr pending
//   issue_ready              : low when issue_addr is already pending
//   clr_valid/clr_addr       : long-latency writeback accepted, clears addr
//   look0_addr/look0_pending : pending lookup for the ALU requester
//   look1_addr/look1_pending : pending lookup for the long-latency requester
//   rd_addr_a/rd_addr_b      : decode source registers
//   rf_write/rf_write_addr   : output-stage write currently in flight
//   hazard_a/hazard_b        : source not yet committed to reg_file
// ---------------------------------------------------------------------------
module wb_scoreboard
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       issue_valid,
  input  logic [4:0] issue_addr,
  output logic       issue_ready,
  input  logic       clr_valid,
  input  logic [4:0] clr_addr,
  input  logic [4:0] look0_addr,
  output logic       look0_pending,
  input  logic [4:0] look1_addr,
  output logic       look1_pending,
  input  logic [4:0] rd_addr_a,
  input  logic [4:0] rd_addr_b,
  input  logic       rf_write,
  input  logic [4:0] rf_write_addr,
  output logic       hazard_a,
  output logic       hazard_b
);

  // Bit 0 exists only to keep indexing simple; it is forced low every cycle.
  logic [31:0] pending;
  logic [31:0] pending_next;
  logic        set_en;

  assign issue_ready   = (issue_addr == REG_ZERO) || !pending[issue_addr];
  assign set_en        = issue_valid && issue_ready && (issue_addr != REG_ZERO);
  assign look0_pending = pending[look0_addr];
  assign look1_pending = pending[look1_addr];

  // A source is unsafe while its producer is still outstanding, and also for
  // the one cycle its value sits in the output register on its way in.
  assign hazard_a = (rd_addr_a != REG_ZERO) &&
                    (pending[rd_addr_a] || (rf_write && (rf_write_addr == rd_addr_a)));
  assign hazard_b = (rd_addr_b != REG_ZERO) &&
                    (pending[rd_addr_b] || (rf_write && (rf_write_addr == rd_addr_b)));

  // Next pending vector: the clear is applied first so that a same-cycle
  // issue to the same register overrides it and the new op stays tracked.
  always_comb begin
    pending_next = pending;
    if (clr_valid)
      pending_next[clr_addr] = 1'b0;
    if (set_en)
      pending_next[issue_addr] = 1'b1;
    pending_next[0] = 1'b0;
  end

  // Pending state; everything outstanding is forgotten on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pending <= '0;
    else
      pending <= pending_next;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
// Shares the single reg_file write port between the ALU writeback (req0)
// and the long-latency writeback (req1), with a starvation guard for req1,
// a pending-write scoreboard and decode hazard flags.
// Ports:
//   clk, reset                        : clock, async active-high reset
//   req0_valid/ready/addr/data        : ALU writeback handshake
//   req1_valid/ready/addr/data        : long-latency writeback handshake
//   issue_valid/issue_addr/issue_ready: long-latency issue into scoreboard
//   rd_addr_a/rd_addr_b, hazard_a/b   : decode-stage hazard lookup
//   rf_write/rf_write_addr/rf_data_in : registered reg_file write port
//   err_waw                           : sticky write-after-write error
// ---------------------------------------------------------------------------
module regfile_wb_arbiter
  import mips_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [4:0]        req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [4:0]        req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              issue_valid,
  input  logic [4:0]        issue_addr,
  output logic              issue_ready,
  input  logic [4:0]        rd_addr_a,
  input  logic [4:0]        rd_addr_b,
  output logic              hazard_a,
  output logic              hazard_b,
  output logic              rf_write,
  output logic [4:0]        rf_write_addr,
  output logic [DATA_W-1:0] rf_data_in,
  output logic              err_waw
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  logic       force1;
  logic       acc0;
  logic       acc1;
  logic       pend0;
  logic       pend1;

  // req0 normally wins; once req1 has waited LIMIT cycles it is forced in.
  // The two readies can never both accept in the same cycle.
  assign force1     = (starve_cnt == LIMIT);
  assign req0_ready = !force1;
  assign req1_ready = force1 || !req0_valid;
  assign acc0       = req0_valid && req0_ready;
  assign acc1       = req1_valid && req1_ready;

  wb_scoreboard u_scoreboard (
    .clk           (clk),
    .reset         (reset),
    .issue_valid   (issue_valid),
    .issue_addr    (issue_addr),
    .issue_ready   (issue_ready),
    .clr_valid     (acc1),
    .clr_addr      (req1_addr),
    .look0_addr    (req0_addr),
    .look0_pending (pend0),
    .look1_addr    (req1_addr),
    .look1_pending (pend1),
    .rd_addr_a     (rd_addr_a),
    .rd_addr_b     (rd_addr_b),
    .rf_write      (rf_write),
    .rf_write_addr (rf_write_addr),
    .hazard_a      (hazard_a),
    .hazard_b      (hazard_b)
  );

  // Output stage: capture the accepted request so the reg_file sees it on
  // the next edge. A write to register 0 completes the handshake but never
  // raises the write strobe. Address and data hold when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_write      <= 1'b0;
      rf_write_addr <= '0;
      rf_data_in    <= '0;
    end else if (acc0) begin
      rf_write      <= (req0_addr != REG_ZERO);
      rf_write_addr <= req0_addr;
      rf_data_in    <= req0_data;
    end else if (acc1) begin
      rf_write      <= (req1_addr != REG_ZERO);
      rf_write_addr <= req1_addr;
      rf_data_in    <= req1_data;
    end else begin
      rf_write      <= 1'b0;
    end
  end

  // Starvation counter: counts consecutive blocked cycles of req1 and
  // saturates at the limit, which is what raises force1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      starve_cnt <= '0;
    else if (!req1_valid || acc1)
      starve_cnt <= '0;
    else if (starve_cnt != LIMIT)
      starve_cnt <= starve_cnt + 4'd1;
  end

  // Sticky protocol error: the ALU writing a register a long-latency op
  // still owns, or a long-latency result arriving for a register nobody
  // issued. The write itself is not blocked.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err_waw <= 1'b0;
    else if ((acc0 && pend0) ||
             (acc1 && (req1_addr != REG_ZERO) && !pend1))
      err_waw <= 1'b1;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Directed vector table plus hand-written starvation and reset sequences.
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready;
  logic [4:0]  req0_addr;
  logic [31:0] req0_data;
  logic        req1_valid, req1_ready;
  logic [4:0]  req1_addr;
  logic [31:0] req1_data;
  logic        issue_valid, issue_ready;
  logic [4:0]  issue_addr;
  logic [4:0]  rd_addr_a, rd_addr_b;
  logic        hazard_a, hazard_b;
  logic        rf_write;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_data_in;
  logic        err_waw;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.STARVE_LIMIT(4), .DATA_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .req0_valid    (req0_valid),
    .req0_ready    (req0_ready),
    .req0_addr     (req0_addr),
    .req0_data     (req0_data),
    .req1_valid    (req1_valid),
    .req1_ready    (req1_ready),
    .req1_addr     (req1_addr),
    .req1_data     (req1_data),
    .issue_valid   (issue_valid),
    .issue_addr    (issue_addr),
    .issue_ready   (issue_ready),
    .rd_addr_a     (rd_addr_a),
    .rd_addr_b     (rd_addr_b),
    .hazard_a      (hazard_a),
    .hazard_b      (hazard_b),
    .rf_write      (rf_write),
    .rf_write_addr (rf_write_addr),
    .rf_data_in    (rf_data_in),
    .err_waw       (err_waw)
  );

  // One cycle of stimulus with the outputs it must produce: the first group
  // is checked before the edge, the second group just after it.
  typedef struct {
    logic        r0v; logic [4:0] r0a; logic [31:0] r0d;
    logic        r1v; logic [4:0] r1a; logic [31:0] r1d;
    logic        iv;  logic [4:0] ia;
    logic [4:0]  ra;  logic [4:0] rb;
    logic        e_r0rdy; logic e_r1rdy; logic e_irdy; logic e_ha; logic e_hb;
    logic        e_wr; logic [4:0] e_wa; logic [31:0] e_wd; logic e_err;
  } vec_t;

  vec_t vecs [14];

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    req0_valid  = v.r0v; req0_addr = v.r0a; req0_data = v.r0d;
    req1_valid  = v.r1v; req1_addr = v.r1a; req1_data = v.r1d;
    issue_valid = v.iv;  issue_addr = v.ia;
    rd_addr_a   = v.ra;  rd_addr_b  = v.rb;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    // Vector fields: req0 v/a/d, req1 v/a/d, issue v/a, rd a/b,
    // then pre-edge r0rdy r1rdy irdy ha hb, then post-edge wr wa wd err.
    vecs[0]  = '{1,3,'h1234, 0,0,0,       0,0, 3,0, 1,0,1,0,0, 1,3,'h1234,0};
    vecs[1]  = '{0,0,0,      0,0,0,       0,0, 3,0, 1,1,1,1,0, 0,3,'h1234,0};
    vecs[2]  = '{0,0,0,      0,0,0,       1,9, 9,0, 1,1,1,0,0, 0,3,'h1234,0};
    vecs[3]  = '{0,0,0,      0,0,0,       1,9, 9,3, 1,1,0,1,0, 0,3,'h1234,0};
    vecs[4]  = '{0,0,0,      1,9,'hABCD,  0,0, 9,0, 1,1,1,1,0, 1,9,'hABCD,0};
    vecs[5]  = '{0,0,0,      0,0,0,       0,0, 9,0, 1,1,1,1,0, 0,9,'hABCD,0};
    vecs[6]  = '{0,0,0,      0,0,0,       0,0, 9,0, 1,1,1,0,0, 0,9,'hABCD,0};
    vecs[7]  = '{0,0,0,      1,0,'hFFFF,  1,9, 0,0, 1,1,1,0,0, 0,0,'hFFFF,0};
    vecs[8]  = '{1,9,'h5555, 0,0,0,       0,0, 9,0, 1,0,1,1,0, 1,9,'h5555,1};
    vecs[9]  = '{0,0,0,      0,0,0,       0,0, 9,0, 1,1,1,1,0, 0,9,'h5555,1};
    vecs[10] = '{0,0,0,      1,7,'h77,    1,7, 0,7, 1,1,1,0,0, 1,7,'h77,1};
    vecs[11] = '{0,0,0,      0,0,0,       0,0, 9,7, 1,1,1,1,1, 0,7,'h77,1};
    vecs[12] = '{0,0,0,      0,0,0,       1,7, 0,7, 1,1,0,0,1, 0,7,'h77,1};
    vecs[13] = '{0,0,0,      1,9,'h1,     0,0, 9,0, 1,1,1,1,0, 1,9,'h1,1};

    reset = 1'b1;
    req0_valid = 0; req0_addr = 0; req0_data = 0;
    req1_valid = 0; req1_addr = 0; req1_data = 0;
    issue_valid = 0; issue_addr = 0; rd_addr_a = 0; rd_addr_b = 0;
    #3;
    checkOutput("reset_rf_write", 32'(rf_write), 0);
    checkOutput("reset_rf_addr", 32'(rf_write_addr), 0);
    checkOutput("reset_rf_data", rf_data_in, 0);
    checkOutput("reset_err", 32'(err_waw), 0);
    @(negedge clk);
    reset = 1'b0;

    // Directed table.
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i]);
      #2;
      checkOutput($sformatf("v%0d_req0_ready", i), 32'(req0_ready), 32'(vecs[i].e_r0rdy));
      checkOutput($sformatf("v%0d_req1_ready", i), 32'(req1_ready), 32'(vecs[i].e_r1rdy));
      checkOutput($sformatf("v%0d_issue_ready", i), 32'(issue_ready), 32'(vecs[i].e_irdy));
      checkOutput($sformatf("v%0d_hazard_a", i), 32'(hazard_a), 32'(vecs[i].e_ha));
      checkOutput($sformatf("v%0d_hazard_b", i), 32'(hazard_b), 32'(vecs[i].e_hb));
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d_rf_write", i), 32'(rf_write), 32'(vecs[i].e_wr));
      checkOutput($sformatf("v%0d_rf_addr", i), 32'(rf_write_addr), 32'(vecs[i].e_wa));
      checkOutput($sformatf("v%0d_rf_data", i), rf_data_in, vecs[i].e_wd);
      checkOutput($sformatf("v%0d_err", i), 32'(err_waw), 32'(vecs[i].e_err));
    end

    // Starvation: both requesters valid every cycle; req0 wins four times,
    // req1 is forced on the fifth, then req0 resumes.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      req0_valid = 1; req0_addr = 5'd1; req0_data = 32'(k);
      req1_valid = 1; req1_addr = 5'd2; req1_data = 32'h100 + 32'(k);
      issue_valid = 0; issue_addr = 0; rd_addr_a = 0; rd_addr_b = 0;
      #2;
      checkOutput($sformatf("starve%0d_req0_ready", k), 32'(req0_ready), (k == 4) ? 0 : 1);
      checkOutput($sformatf("starve%0d_req1_ready", k), 32'(req1_ready), (k == 4) ? 1 : 0);
      @(posedge clk);
      #1;
      checkOutput($sformatf("starve%0d_rf_write", k), 32'(rf_write), 1);
      checkOutput($sformatf("starve%0d_rf_addr", k), 32'(rf_write_addr), (k == 4) ? 2 : 1);
      checkOutput($sformatf("starve%0d_rf_data", k), rf_data_in,
                  (k == 4) ? 32'h100 + 32'(k) : 32'(k));
    end

    // Reset mid-stream: register 5 pending and a write in flight.
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    issue_valid = 1; issue_addr = 5'd5;
    @(negedge clk);
    issue_valid = 0; issue_addr = 5'd5;
    req0_valid = 1; req0_addr = 5'd4; req0_data = 32'h44;
    rd_addr_a = 5'd5;
    #2;
    checkOutput("pre_reset_hazard_a", 32'(hazard_a), 1);
    checkOutput("pre_reset_issue_ready", 32'(issue_ready), 0);
    @(posedge clk);
    #1;
    checkOutput("pre_reset_rf_write", 32'(rf_write), 1);
    req0_valid = 0;
    reset = 1'b1;
    #1;
    checkOutput("midreset_rf_write", 32'(rf_write), 0);
    checkOutput("midreset_rf_addr", 32'(rf_write_addr), 0);
    checkOutput("midreset_rf_data", rf_data_in, 0);
    checkOutput("midreset_hazard_a", 32'(hazard_a), 0);
    checkOutput("midreset_issue_ready", 32'(issue_ready), 1);
    checkOutput("midreset_err", 32'(err_waw), 0);
    @(negedge clk);
    reset = 1'b0;
    req0_valid = 1; req0_addr = 5'd6; req0_data = 32'h66;
    req1_valid = 1; req1_addr = 5'd8; req1_data = 32'h88;
    #2;
    checkOutput("postreset_req0_ready", 32'(req0_ready), 1);
    checkOutput("postreset_req1_ready", 32'(req1_ready), 0);
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
